// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//   Asynchronous serial byte receiver. Samples rxd_i through a 2-flop synchronizer, deframes
//   8N1 characters (LSB first) at CLKS_PER_BIT clocks per bit and presents each byte on a
//   one-entry ready/valid holding register. Start-bit glitches are filtered, framing errors
//   and overruns are reported as one-cycle pulses.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> 8E1 frame, parity bit checked, parity_err_o driven.
//     undefined -> 8N1 frame, parity_err_o tied to 0.
//
//   Parameters
//     CLKS_PER_BIT  clock cycles per bit, must be >= 4
//   Ports
//     clk_i         clock, rising edge
//     rst_i         asynchronous active-high reset
//     rxd_i         serial line, idle high, asynchronous to clk_i
//     rx_data_o     received byte, stable while rx_valid_o is high
//     rx_valid_o    holding register full
//     rx_ready_i    consumer accepts the byte when rx_valid_o & rx_ready_i
//     frame_err_o   one-cycle pulse: stop bit sampled low
//     parity_err_o  one-cycle pulse: even-parity mismatch (parity build only)
//     overrun_o     one-cycle pulse: byte completed while holding register full
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 263
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int unsigned     HALF       = CLKS_PER_BIT / 2;
  localparam int unsigned     CntW       = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntBitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntOne     = CntW'(1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
    StParity   = 3'd3,
`endif
    StStop     = 3'd4,
    StWaitHigh = 3'd5
  } state_e;

  logic            sync1_q;
  logic            rxs_q;
  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            cnt_bit_end;
`ifdef UART_RX_PARITY_EN
  logic            par_bit_q;
`endif

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxs_q   <= sync1_q;
    end
  end

  assign cnt_bit_end = (cnt_q == CntBitEnd);

`ifndef UART_RX_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_o <= 1'b0;
`endif
      // Handshake empties the register unless a delivery below reloads it.
      if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (!rxs_q) begin
            state_q <= StStart;
          end
        end

        // Re-check the line mid start bit; a high line means a glitch.
        StStart: begin
          if (cnt_q == CntHalfEnd) begin
            cnt_q   <= '0;
            state_q <= rxs_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        StData: begin
          if (cnt_bit_end) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rxs_q;
            bit_idx_q          <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (cnt_bit_end) begin
            cnt_q     <= '0;
            par_bit_q <= rxs_q;
            state_q   <= StStop;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
`endif

        // Leaving at mid stop bit lets a start edge half a bit later be caught.
        StStop: begin
          if (cnt_bit_end) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (!rxs_q) begin
              frame_err_o <= 1'b1;
              state_q     <= StWaitHigh;
`ifdef UART_RX_PARITY_EN
            end else if (par_bit_q != ^shift_q) begin
              parity_err_o <= 1'b1;
`endif
            end else if (!rx_valid_o || rx_ready_i) begin
              rx_data_o  <= shift_q;
              rx_valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end

        // Break or stuck-low line: wait for idle before hunting for a start bit.
        StWaitHigh: begin
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx
//   Directed bench for uart_byte_rx at the default 263 clocks per bit. A frame-level model
//   turns each driven character into one expected event (delivery, framing error or parity
//   error) due a fixed latency after the start edge, and tracks the holding register from
//   those events and rx_ready. One compare process checks every DUT output against it each
//   cycle; literal expectations pin latency, captured bytes and pulse counts.
module tb_uart_byte_rx;

  localparam int unsigned CPB  = 263;
  localparam int unsigned HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS   = 11;
  localparam int unsigned LAT     = 2 + HALF + 10 * CPB;
  localparam int unsigned EXP_LAT = 2763;
`else
  localparam int unsigned NBITS   = 10;
  localparam int unsigned LAT     = 2 + HALF + 9 * CPB;
  localparam int unsigned EXP_LAT = 2500;
`endif

  typedef enum int {EvDeliver, EvFrame, EvParity} ev_kind_e;
  typedef struct {
    longint     cyc;
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       rxd      = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rxd_i       (rxd),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .frame_err_o (frame_err),
    .parity_err_o(parity_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model, advanced on every rising edge.
  ev_t        evq[$];
  longint     cyc     = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_frame = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_over  = 1'b0;

  always @(posedge clk) begin
    bit  hs;
    ev_t ev;
    cyc     = cyc + 1;
    m_frame = 1'b0;
    m_perr  = 1'b0;
    m_over  = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      hs = m_valid && rx_ready;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          EvDeliver: begin
            if (!m_valid || rx_ready) begin
              m_data  = ev.data;
              m_valid = 1'b1;
              hs      = 1'b0;
            end else begin
              m_over = 1'b1;
            end
          end
          EvFrame: m_frame = 1'b1;
          default: m_perr = 1'b1;
        endcase
      end
      if (hs) m_valid = 1'b0;
    end
  end

  // Compare process plus counters for the literal checks.
  logic       prev_valid   = 1'b0;
  longint     rise_cyc     = 0;
  logic [7:0] last_byte    = 8'h00;
  int         valid_cycles = 0;
  int         frame_cnt    = 0;
  int         perr_cnt     = 0;
  int         over_cnt     = 0;

  always @(posedge clk) begin
    #2;
    check("valid", {31'd0, rx_valid}, {31'd0, m_valid});
    if (m_valid) check("data", {24'd0, rx_data}, {24'd0, m_data});
    check("err_pulses", {29'd0, frame_err, parity_err, overrun}, {29'd0, m_frame, m_perr, m_over});
    if (rx_valid && !prev_valid) begin
      rise_cyc  = cyc;
      last_byte = rx_data;
    end
    prev_valid   = rx_valid;
    valid_cycles += int'(rx_valid);
    frame_cnt    += int'(frame_err);
    perr_cnt     += int'(parity_err);
    over_cnt     += int'(overrun);
  end

  task automatic clear_counts();
    valid_cycles = 0;
    frame_cnt    = 0;
    perr_cnt     = 0;
    over_cnt     = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  longint last_fall = 0;

  // Drives one character; pulse_ready raises rx_ready only across the delivery edge,
  // abort_at >= 0 asserts reset at that cycle of the frame and returns.
  task automatic send(input logic [7:0] d, input logic stop_bit, input bit par_flip,
                      input bit pulse_ready, input int abort_at);
    logic [10:0] bits;
    ev_t         ev;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_RX_PARITY_EN
    bits[9]   = (^d) ^ par_flip;
    bits[10]  = stop_bit;
`else
    bits[9]   = stop_bit;
`endif
    for (int i = 0; i < int'(NBITS * CPB); i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst = 1'b1;
        return;
      end
      rxd = bits[i / CPB];
      if (i == 0) begin
        last_fall = cyc;
        ev.cyc    = cyc + 1 + LAT;
        ev.data   = d;
        ev.kind   = !stop_bit ? EvFrame : (par_flip ? EvParity : EvDeliver);
        evq.push_back(ev);
      end
      if (pulse_ready && i == int'(LAT))     rx_ready = 1'b1;
      if (pulse_ready && i == int'(LAT) + 1) rx_ready = 1'b0;
    end
  endtask

  initial begin
    idle(5);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_errs", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b0;
    idle(20);

    // Basic receive
    clear_counts();
    send(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    check("latency_5a", 32'(rise_cyc - (last_fall + 1)), EXP_LAT);
    check("byte_5a", {24'd0, last_byte}, 32'h5A);
    check("valid_len_5a", valid_cycles, 1);
    check("errs_5a", frame_cnt + perr_cnt + over_cnt, 0);

    // Start-bit glitch
    clear_counts();
    @(negedge clk) rxd = 1'b0;
    idle(49);
    @(negedge clk) rxd = 1'b1;
    idle(300);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_errs", frame_cnt + perr_cnt + over_cnt, 0);
    send(8'hA5, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    check("byte_a5", {24'd0, last_byte}, 32'hA5);
    check("valid_len_a5", valid_cycles, 1);

    // Framing error, line held low, then recovery
    clear_counts();
    send(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    idle(1000);
    @(negedge clk) rxd = 1'b1;
    idle(50);
    check("frame_err_cnt", frame_cnt, 1);
    check("frame_no_valid", valid_cycles, 0);
    send(8'hC3, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    check("byte_c3", {24'd0, last_byte}, 32'hC3);

    // Backpressure and overrun
    @(negedge clk) rx_ready = 1'b0;
    clear_counts();
    send(8'h11, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    send(8'h22, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    check("held_data_11", {24'd0, rx_data}, 32'h11);
    check("held_valid", {31'd0, rx_valid}, 32'd1);
    check("overrun_cnt", over_cnt, 1);
    @(negedge clk) rx_ready = 1'b1;
    @(posedge clk);
    #2;
    check("valid_drop", {31'd0, rx_valid}, 32'd0);
    @(negedge clk) rx_ready = 1'b0;

    // Coincident accept on the delivery edge
    clear_counts();
    send(8'h33, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    send(8'h44, 1'b1, 1'b0, 1'b1, -1);
    idle(20);
    check("coinc_data_44", {24'd0, rx_data}, 32'h44);
    check("coinc_valid", {31'd0, rx_valid}, 32'd1);
    check("coinc_no_overrun", over_cnt, 0);

    // Reset during bit 4 of 0xFF while 0x44 is held
    send(8'hFF, 1'b1, 1'b0, 1'b0, int'(5 * CPB + HALF));
    #1;
    check("midrst_valid", {31'd0, rx_valid}, 32'd0);
    check("midrst_data", {24'd0, rx_data}, 32'd0);
    check("midrst_errs", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    rxd = 1'b1;
    idle(10);
    rst      = 1'b0;
    rx_ready = 1'b1;
    idle(20);
    clear_counts();
    send(8'h81, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    check("byte_81", {24'd0, last_byte}, 32'h81);
    check("valid_len_81", valid_cycles, 1);

`ifdef UART_RX_PARITY_EN
    clear_counts();
    send(8'h01, 1'b1, 1'b0, 1'b0, -1);
    idle(20);
    check("par_good_byte", {24'd0, last_byte}, 32'h01);
    check("par_good_no_err", perr_cnt, 0);
    clear_counts();
    send(8'h01, 1'b1, 1'b1, 1'b0, -1);
    idle(20);
    check("par_bad_err", perr_cnt, 1);
    check("par_bad_no_valid", valid_cycles, 0);
`endif

    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Asynchronous-serial byte receiver for the uart_alu datapath: samples the `rxd_i` line, deframes 8N1 characters (LSB first) at a fixed clock-per-bit ratio and presents each byte on a one-entry ready/valid holding register. It is the receiving end of the byte stream the bench drives into `uart_alu` (115200 baud at the ~30.3 MHz bench clock) and feeds the ALU packet parser. Start-bit glitches are filtered, framing errors are flagged, and overruns under backpressure are reported.

## Interface
- `CLKS_PER_BIT`, default 263: clock cycles per bit; must be ≥ 4. `HALF` = floor(`CLKS_PER_BIT`/2).
- `clk_i`  input  1  clock; all logic on the rising edge.
- `rst_i`  input  1  reset; asynchronous, active-high.
- `rxd_i`  input  1  serial line, idle high, asynchronous to `clk_i`.
- `rx_data_o`  output  8  received byte; valid while `rx_valid_o` is high.
- `rx_valid_o`  output  1  holding register full.
- `rx_ready_i`  input  1  consumer accepts the byte when `rx_valid_o & rx_ready_i`.
- `frame_err_o`  output  1  one-cycle pulse: stop bit sampled low.
- `parity_err_o`  output  1  one-cycle pulse: parity mismatch (only with `UART_RX_PARITY_EN`).
- `overrun_o`  output  1  one-cycle pulse: byte completed while the holding register was full.

## Operation
- `rxd_i` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM sees only the synchronized value `rxs`.
- A cycle counter and a 3-bit bit index drive the FSM. The counter clears on every state change.
- States:
  - IDLE: `rxs`==0 → START.
  - START: at count `HALF`-1, sample `rxs`. 0 → DATA. 1 → IDLE (glitch, no flag).
  - DATA: at count `CLKS_PER_BIT`-1, shift `rxs` into bit [index], LSB first. After bit 7 → STOP, or → PARITY when the macro is defined.
  - PARITY: at count `CLKS_PER_BIT`-1, sample the parity bit, then → STOP.
  - STOP: at count `CLKS_PER_BIT`-1, sample `rxs`. If 1 and parity is good, deliver the byte and → IDLE. If 0: pulse `frame_err_o`, drop the byte, → WAIT_HIGH. If parity is bad with a good stop bit: pulse `parity_err_o`, drop the byte, → IDLE.
  - WAIT_HIGH: stay until `rxs`==1 (break/stuck-low line), then → IDLE.
- Delivery rules:
  - Holding register empty: load `rx_data_o` and set `rx_valid_o`.
  - Register full and `rx_ready_i`==1 in the same cycle: the old byte is consumed, the new byte is loaded, `rx_valid_o` stays 1, no overrun.
  - Register full and `rx_ready_i`==0: pulse `overrun_o`, discard the new byte, keep the old one.
- `rx_valid_o` clears on the cycle after the handshake (`rx_valid_o & rx_ready_i`) when no delivery coincides.
- `rx_data_o` is stable while `rx_valid_o` is high.
- Reset, including mid-character: FSM → IDLE, counter/index → 0, `rx_data_o`=0x00, `rx_valid_o`=0, all error outputs 0. A partially received character is lost.

## Timing
- The FSM acts on `rxd_i` 2 cycles after a pin change (synchronizer).
- Latency, 8N1: `rx_valid_o` rises 2 + `HALF` + 9·`CLKS_PER_BIT` cycles after the first clock edge that samples `rxd_i` low. With the default this is 2500 cycles.
- Latency with parity: add `CLKS_PER_BIT`.
- `frame_err_o`, `parity_err_o` and `overrun_o` each assert on the same edge on which a delivery would have occurred, for exactly 1 cycle.
- Back-to-back characters: from STOP the FSM returns to IDLE at the middle of the stop bit. A start edge half a bit later is caught, so a line at full rate is received with no gaps.
- Throughput: 1 byte per 10 (or 11 with parity) bit times. The consumer must accept each byte within one character time to avoid overrun.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1. The PARITY state is present, the even-parity bit is checked, and `parity_err_o` is driven.
- `UART_RX_PARITY_EN` undefined: the frame is 8N1. There is no PARITY state and `parity_err_o` is tied to 0.

## Test plan
- **Basic receive:** reset, `rx_ready_i`=1, send 0x5A at 8680 ns/bit → `rx_valid_o` high for 1 cycle with `rx_data_o`=0x5A, rising 2500±1 cycles after the start edge; no error pulses.
- **Start-bit glitch:** drive `rxd_i` low for 50 cycles, then high → no `rx_valid_o` and no error; a following 0xA5 is received correctly.
- **Framing error:** send 0x3C with the stop bit low, then hold the line low for 1000 cycles → one `frame_err_o` pulse and no `rx_valid_o`. After the line returns high, 0xC3 is received correctly.
- **Backpressure and overrun:**
  - With `rx_ready_i`=0, send 0x11 then 0x22 → `rx_data_o`=0x11 is held and `overrun_o` pulses once at the completion of 0x22.
  - Raise `rx_ready_i` → `rx_valid_o` drops the next cycle.
  - Coincident-accept check: with `rx_ready_i` pulsed on the delivery edge, no overrun and the new byte is loaded.
- **Reset mid-byte:** assert `rst_i` during bit 4 of 0xFF → all outputs 0 immediately. After release, 0x81 is received correctly.
- **Parity (`UART_RX_PARITY_EN`):**
  - 0x01 with parity bit 1 → delivered.
  - 0x01 with parity bit 0 → one `parity_err_o` pulse and no `rx_valid_o`.
